// File: rtl/adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// adc_sample_fifo
//   Elastic first-word-fall-through buffer between the free-running ADC sample
//   stream and the packetizer AXI-Stream input. Absorbs downstream stalls,
//   drops and counts samples that arrive while the buffer is full, and reports
//   the current fill level.
//
//   Optional build macro:
//     ADC_FIFO_WATERMARK_EN - adds output max_level, the highest fill level
//                             observed since reset or the last clear_status.
// -----------------------------------------------------------------------------
module adc_sample_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int DROP_CNT_W = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  clear_status,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
`ifdef ADC_FIFO_WATERMARK_EN
    ,
    output logic [DEPTH_LOG2:0]   max_level
`endif
);

    localparam int                   DEPTH     = 1 << DEPTH_LOG2;
    localparam int                   LVL_W     = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]     LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]     LVL_ONE   = LVL_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DROP_CNT_W-1:0] CNT_ONE  = DROP_CNT_W'(1);

    // Sample storage and its pointers; pointers wrap modulo DEPTH by width.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic drop_cnt_sat;

    // A slot frees up in the same cycle as a pop, so a full FIFO with the
    // consumer ready still accepts the incoming sample. flush overrides
    // everything: the sample offered alongside it is neither stored nor
    // counted as a drop.
    assign full         = (level_q == LVL_FULL);
    assign pop          = m_axis_tvalid & m_axis_tready;
    assign push         = enable & sample_valid & (~full | pop) & ~flush;
    assign drop         = enable & sample_valid & full & ~pop & ~flush;
    assign drop_cnt_sat = &drop_count;

    // First-word-fall-through: head entry presented combinationally.
    assign m_axis_tdata  = mem[rd_ptr];
    assign m_axis_tvalid = (level_q != '0);
    assign level         = level_q;

    // Next fill level: net change of push and pop, cleared by flush.
    always_comb begin
        // NOTE: level_d gets a default before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    // Pointer and level registers; reset and flush both empty the FIFO.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sample storage write port.
    always_ff @(posedge aclk) begin
        // NOTE: the storage array has no reset; its contents are only ever
        // observed through rd_ptr after a push, and leaving it unreset lets it
        // map onto block RAM.
        if (push) mem[wr_ptr] <= sample_data;
    end

    // Sticky overflow flag and saturating drop counter; clear wins over a drop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (!drop_cnt_sat) drop_count <= drop_count + CNT_ONE;
        end
    end

`ifdef ADC_FIFO_WATERMARK_EN
    // High-water mark: follows level one cycle late, reloaded by clear_status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            max_level <= '0;
        end else if (clear_status) begin
            max_level <= level_q;
        end else if (level_q > max_level) begin
            max_level <= level_q;
        end
    end
`endif

endmodule

// File: tb/tb_adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_fifo
//   Self-checking bench for adc_sample_fifo (DEPTH_LOG2=4, DROP_CNT_W=4).
//   A queue-based reference model tracks contents, drops and the watermark.
// -----------------------------------------------------------------------------
module tb_adc_sample_fifo;

    localparam int DW    = 32;
    localparam int DL    = 4;
    localparam int CW    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int LW    = DL + 1;
    localparam int MAXC  = (1 << CW) - 1;

    logic          aclk;
    logic          aresetn;
    logic          enable;
    logic          flush;
    logic          clear_status;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [LW-1:0] level;
    logic          overflow;
    logic [CW-1:0] drop_count;
`ifdef ADC_FIFO_WATERMARK_EN
    logic [LW-1:0] max_level;
`endif

    adc_sample_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH_LOG2(DL),
        .DROP_CNT_W(CW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .flush        (flush),
        .clear_status (clear_status),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count)
`ifdef ADC_FIFO_WATERMARK_EN
        ,
        .max_level    (max_level)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    int            m_dc  = 0;
    bit            m_ov  = 0;
    int            m_max = 0;

    task automatic model_reset();
        m_q.delete();
        m_dc  = 0;
        m_ov  = 0;
        m_max = 0;
    endtask

    // Apply one clock of stimulus, advance the model, return #1 after the edge.
    task automatic step(input bit en, input bit sv, input logic [DW-1:0] d,
                        input bit rdy, input bit fl, input bit cs);
        int lvl0;
        bit pop;
        bit drop;
        enable       = en;
        sample_valid = sv;
        sample_data  = d;
        m_axis_tready = rdy;
        flush        = fl;
        clear_status = cs;
        lvl0 = m_q.size();
        pop  = (lvl0 != 0) && rdy;
        drop = 0;
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (en && sv) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else drop = 1;
            end
        end
        if (cs) begin
            m_dc = 0;
            m_ov = 0;
        end else if (drop) begin
            m_ov = 1;
            if (m_dc < MAXC) m_dc++;
        end
        if (cs) m_max = lvl0;
        else if (lvl0 > m_max) m_max = lvl0;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        enable = 0; sample_valid = 0; sample_data = '0;
        m_axis_tready = 0; flush = 0; clear_status = 0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        n_vec++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d, expected 0", level); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b, expected 0", m_axis_tvalid); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL reset_drop_count: got %0d, expected 0", drop_count); end
`ifdef ADC_FIFO_WATERMARK_EN
        n_vec++; if (max_level !== '0) begin n_err++; $display("FAIL reset_max_level: got %0d, expected 0", max_level); end
`endif
        aresetn = 1'b1;
    endtask

    // Push 0..16 with the consumer stalled, then drain in order.
    task automatic test_fill_overflow();
        for (int i = 0; i <= DEPTH; i++) step(1, 1, DW'(i), 0, 0, 0);
        n_vec++; if (level !== LW'(m_q.size())) begin n_err++; $display("FAIL fill_level: got %0d, expected %0d", level, m_q.size()); end
        n_vec++; if (drop_count !== CW'(m_dc)) begin n_err++; $display("FAIL fill_drop_count: got %0d, expected %0d", drop_count, m_dc); end
        n_vec++; if (overflow !== m_ov) begin n_err++; $display("FAIL fill_overflow: got %b, expected %b", overflow, m_ov); end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== m_q[0]) begin
                n_err++;
                $display("FAIL drain_order[%0d]: got valid=%b data=%0h, expected valid=1 data=%0h",
                         i, m_axis_tvalid, m_axis_tdata, m_q[0]);
            end
            step(0, 0, '0, 1, 0, 0);
        end
        n_vec++; if (level !== '0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got level=%0d valid=%b, expected 0/0", level, m_axis_tvalid); end
    endtask

    // Full FIFO with simultaneous push and pop holds its level without drops.
    task automatic test_back_to_back();
        while (m_q.size() < DEPTH) step(1, 1, $urandom, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, $urandom, 1, 0, 0);
            n_vec++;
            if (level !== LW'(DEPTH) || drop_count !== CW'(m_dc) || m_axis_tdata !== m_q[0]) begin
                n_err++;
                $display("FAIL b2b[%0d]: got level=%0d drops=%0d data=%0h, expected level=%0d drops=%0d data=%0h",
                         i, level, drop_count, m_axis_tdata, DEPTH, m_dc, m_q[0]);
            end
        end
        while (m_q.size() > 0) begin
            n_vec++;
            if (m_axis_tdata !== m_q[0]) begin n_err++; $display("FAIL b2b_drain: got %0h, expected %0h", m_axis_tdata, m_q[0]); end
            step(0, 0, '0, 1, 0, 0);
        end
    endtask

    // A single push into an empty FIFO is visible on the next cycle.
    task automatic test_empty_latency();
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL latency_pre: got valid=%b, expected 0", m_axis_tvalid); end
        step(1, 1, 32'hA5A5_0001, 0, 0, 0);
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA5A5_0001 || level !== LW'(1)) begin
            n_err++;
            $display("FAIL latency_post: got valid=%b data=%0h level=%0d, expected 1/a5a50001/1",
                     m_axis_tvalid, m_axis_tdata, level);
        end
        step(0, 0, '0, 1, 0, 0);
    endtask

    // Drop counter saturates; clear_status coincident with a drop wins.
    task automatic test_saturate_clear();
        while (m_q.size() < DEPTH) step(1, 1, $urandom, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, $urandom, 0, 0, 0);
            n_vec++;
            if (drop_count !== CW'(m_dc)) begin n_err++; $display("FAIL sat_count[%0d]: got %0d, expected %0d", i, drop_count, m_dc); end
        end
        n_vec++; if (drop_count !== CW'(MAXC) || overflow !== 1'b1) begin n_err++; $display("FAIL sat_final: got drops=%0d ovf=%b, expected %0d/1", drop_count, overflow, MAXC); end
        step(1, 1, $urandom, 0, 0, 1);
        n_vec++; if (drop_count !== '0 || overflow !== 1'b0) begin n_err++; $display("FAIL clear_wins: got drops=%0d ovf=%b, expected 0/0", drop_count, overflow); end
`ifdef ADC_FIFO_WATERMARK_EN
        n_vec++; if (max_level !== LW'(m_max)) begin n_err++; $display("FAIL clear_max_level: got %0d, expected %0d", max_level, m_max); end
`endif
    endtask

    // flush beats a coincident push (and pop) and is never counted as a drop.
    task automatic test_flush();
        step(1, 1, $urandom, 0, 1, 0);
        n_vec++;
        if (level !== '0 || m_axis_tvalid !== 1'b0 || drop_count !== CW'(m_dc) || overflow !== m_ov) begin
            n_err++;
            $display("FAIL flush_full: got level=%0d valid=%b drops=%0d ovf=%b, expected 0/0/%0d/%b",
                     level, m_axis_tvalid, drop_count, overflow, m_dc, m_ov);
        end
        for (int i = 0; i < 8; i++) step(1, 1, $urandom, 0, 0, 0);
        n_vec++; if (level !== LW'(8)) begin n_err++; $display("FAIL flush_prefill: got %0d, expected 8", level); end
        step(1, 1, $urandom, 1, 1, 0);
        n_vec++;
        if (level !== '0 || m_axis_tvalid !== 1'b0 || drop_count !== '0) begin
            n_err++;
            $display("FAIL flush_push: got level=%0d valid=%b drops=%0d, expected 0/0/0", level, m_axis_tvalid, drop_count);
        end
        step(1, 1, 32'hCAFE_0042, 0, 0, 0);
        n_vec++; if (m_axis_tdata !== 32'hCAFE_0042 || level !== LW'(1)) begin n_err++; $display("FAIL flush_restart: got data=%0h level=%0d, expected cafe0042/1", m_axis_tdata, level); end
        step(0, 0, '0, 1, 0, 0);
    endtask

    // Asynchronous reset in the middle of a burst empties the FIFO at once.
    task automatic test_reset_mid();
        logic [DW-1:0] second;
        for (int i = 0; i < 9; i++) step(1, 1, $urandom, 0, 0, 0);
        n_vec++; if (level !== LW'(9)) begin n_err++; $display("FAIL mid_prefill: got %0d, expected 9", level); end
        #2;
        aresetn = 1'b0;
        model_reset();
        #1;
        n_vec++; if (level !== '0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_reset: got level=%0d valid=%b, expected 0/0", level, m_axis_tvalid); end
        enable = 0; sample_valid = 0; m_axis_tready = 0; flush = 0; clear_status = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_release: got valid=%b, expected 0", m_axis_tvalid); end
        second = $urandom;
        step(1, 1, 32'h0000_1234, 0, 0, 0);
        n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0000_1234) begin n_err++; $display("FAIL mid_first: got valid=%b data=%0h, expected 1/1234", m_axis_tvalid, m_axis_tdata); end
        step(1, 1, second, 1, 0, 0);
        n_vec++; if (m_axis_tdata !== second || level !== LW'(1)) begin n_err++; $display("FAIL mid_second: got data=%0h level=%0d, expected %0h/1", m_axis_tdata, level, second); end
        step(0, 0, '0, 1, 0, 0);
    endtask

    // Randomized traffic against the model, in stall-heavy then drain-heavy phases.
    task automatic test_random();
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 250; i++) begin
                bit en  = ($urandom_range(0, 7) != 0);
                bit sv  = ($urandom_range(0, 3) != 0);
                bit rdy = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                bit fl  = ($urandom_range(0, 59) == 0);
                bit cs  = ($urandom_range(0, 39) == 0);
                step(en, sv, $urandom, rdy, fl, cs);
                n_vec++;
                if (level !== LW'(m_q.size()) || m_axis_tvalid !== (m_q.size() != 0) ||
                    overflow !== m_ov || drop_count !== CW'(m_dc) ||
                    (m_q.size() != 0 && m_axis_tdata !== m_q[0])) begin
                    n_err++;
                    $display("FAIL random[%0d/%0d]: got level=%0d valid=%b ovf=%b drops=%0d data=%0h, expected level=%0d ovf=%b drops=%0d data=%0h",
                             ph, i, level, m_axis_tvalid, overflow, drop_count, m_axis_tdata,
                             m_q.size(), m_ov, m_dc, (m_q.size() != 0) ? m_q[0] : '0);
                end
`ifdef ADC_FIFO_WATERMARK_EN
                n_vec++;
                if (max_level !== LW'(m_max)) begin n_err++; $display("FAIL random_max[%0d/%0d]: got %0d, expected %0d", ph, i, max_level, m_max); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_back_to_back();
        test_empty_latency();
        test_saturate_clear();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
